// File: rtl/apb_v3_pkg.sv
// Shared APB v3 definitions: FSM state encoding and transfer direction,
// common to the requester and completer sides.
package apb_v3_pkg;

   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic WRITE = 1'b1;
   localparam logic READ  = 1'b0;

endpackage

// File: rtl/apb_v3_master.sv
// APB v3 requester: turns one local command into one SETUP/ACCESS transfer
// and reports completion, slave error or wait-state timeout on rsp_*.
module apb_v3_master
   import apb_v3_pkg::*;
#(
   parameter int unsigned ADDR_BUS_WIDTH = 32,
   parameter int unsigned DATA_BUS_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYC    = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
   input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
   output logic                      rsp_valid,
   output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_BUS_WIDTH-1:0] PADDR,
   output logic [DATA_BUS_WIDTH-1:0] PWDATA,
   input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(TIMEOUT_CYC);

   apb_state_e                r_state, w_state;
   logic [WAIT_CNT_W-1:0]     r_cnt, w_cnt, w_cnt_inc;
   logic                      r_psel, w_psel;
   logic                      r_penable, w_penable;
   logic                      r_pwrite, w_pwrite;
   logic [ADDR_BUS_WIDTH-1:0] r_paddr, w_paddr;
   logic [DATA_BUS_WIDTH-1:0] r_pwdata, w_pwdata;
   logic                      r_rsp_valid, w_rsp_valid;
   logic                      r_rsp_err, w_rsp_err;
   logic                      r_rsp_timeout, w_rsp_timeout;
   logic [DATA_BUS_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
   logic                      w_cmd_ready;

   // The response cycle is held off from accepting, giving a 4-cycle minimum period.
   assign w_cmd_ready = (r_state == IDLE) && !r_rsp_valid && !PRESET;
   assign w_cnt_inc   = r_cnt + WAIT_CNT_W'(1);

   always_comb begin
      w_state       = r_state;
      w_cnt         = r_cnt;
      w_psel        = 1'b0;
      w_penable     = 1'b0;
      w_pwrite      = r_pwrite;
      w_paddr       = r_paddr;
      w_pwdata      = r_pwdata;
      w_rsp_valid   = 1'b0;
      w_rsp_err     = 1'b0;
      w_rsp_timeout = 1'b0;
      w_rsp_rdata   = r_rsp_rdata;
      case (r_state)
         IDLE: begin
            if (cmd_valid && w_cmd_ready) begin
               w_state  = SETUP;
               w_psel   = 1'b1;
               w_pwrite = cmd_write ? WRITE : READ;
               w_paddr  = cmd_addr;
               w_pwdata = cmd_wdata;
               w_cnt    = '0;
            end
         end
         SETUP: begin
            w_state   = ACCESS;
            w_psel    = 1'b1;
            w_penable = 1'b1;
         end
         ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
            // PREADY wins over a timeout landing in the same cycle.
            if (PREADY) begin
               w_state     = IDLE;
               w_psel      = 1'b0;
               w_penable   = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_err   = PSLVERR;
               if (r_pwrite == READ) begin
                  w_rsp_rdata = PRDATA;
               end
            end else begin
               w_cnt = w_cnt_inc;
               if (w_cnt_inc == TIMEOUT_LIM) begin
                  w_state       = IDLE;
                  w_psel        = 1'b0;
                  w_penable     = 1'b0;
                  w_rsp_valid   = 1'b1;
                  w_rsp_err     = 1'b1;
                  w_rsp_timeout = 1'b1;
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_rdata   <= '0;
      end else begin
         r_state       <= w_state;
         r_cnt         <= w_cnt;
         r_psel        <= w_psel;
         r_penable     <= w_penable;
         r_pwrite      <= w_pwrite;
         r_paddr       <= w_paddr;
         r_pwdata      <= w_pwdata;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_err     <= w_rsp_err;
         r_rsp_timeout <= w_rsp_timeout;
         r_rsp_rdata   <= w_rsp_rdata;
      end
   end

   assign cmd_ready   = w_cmd_ready;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_apb_v3_master.sv
// Directed bench for apb_v3_master: single transfers, wait states, slave
// error, timeout boundary, mid-transfer reset and back-to-back commands.
module tb_apb_v3_master;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int n_cmp = 0;
   int n_err = 0;

   // Results of the most recent xfer() call
   int          x_psel, x_pen, x_lat;
   logic        x_stable, x_got, x_err, x_tmo, x_bus_rsp;
   logic [31:0] x_rd;
   logic [1:0]  x_after;

   apb_v3_master #(
      .ADDR_BUS_WIDTH(32),
      .DATA_BUS_WIDTH(32),
      .TIMEOUT_CYC   (16)
   ) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One command from a negedge with cmd_ready high; completer raises PREADY on
   // the ready_at-th ACCESS cycle (0 = never) and also during SETUP when ready_at > 0.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int ready_at, input logic [31:0] rdata, input logic slverr);
      int lat;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      PREADY = 1'b0; PRDATA = rdata; PSLVERR = slverr;
      x_psel = 0; x_pen = 0; x_stable = 1'b1;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         if (PSEL) x_psel++;
         if (PENABLE) x_pen++;
         if (!PSEL || PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata))
            x_stable = 1'b0;
         PREADY = PENABLE ? (x_pen == ready_at) : (ready_at > 0);
         @(negedge PCLK);
         lat++;
      end
      x_lat = lat; x_got = rsp_valid; x_err = rsp_err; x_tmo = rsp_timeout;
      x_rd = rsp_rdata; x_bus_rsp = PSEL | PENABLE;
      PREADY = 1'b0; PSLVERR = 1'b0;
      @(negedge PCLK);
      x_after = {rsp_valid, cmd_ready};
   endtask

   task automatic chk_xfer(input string tag, input int e_psel, input int e_pen, input int e_lat,
                           input logic e_err, input logic e_tmo, input logic [31:0] e_rd);
      chk({tag, "_rsp_seen"},   32'(x_got),     32'd1);
      chk({tag, "_psel_cyc"},   32'(x_psel),    32'(e_psel));
      chk({tag, "_pen_cyc"},    32'(x_pen),     32'(e_pen));
      chk({tag, "_latency"},    32'(x_lat),     32'(e_lat));
      chk({tag, "_bus_stable"}, 32'(x_stable),  32'd1);
      chk({tag, "_bus_idle"},   32'(x_bus_rsp), 32'd0);
      chk({tag, "_err"},        32'(x_err),     32'(e_err));
      chk({tag, "_timeout"},    32'(x_tmo),     32'(e_tmo));
      chk({tag, "_rdata"},      x_rd,           e_rd);
      chk({tag, "_pulse_ready"}, 32'(x_after),  32'd1);
   endtask

   initial begin
      int   rsp_cyc[4];
      int   acc_cyc[4];
      int   n_rsp, n_acc, bad_pen, seen_rsp;
      logic prev_psel, prev_pen;

      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      repeat (2) @(negedge PCLK);

      chk("rst_psel",      32'(PSEL),        32'd0);
      chk("rst_penable",   32'(PENABLE),     32'd0);
      chk("rst_pwrite",    32'(PWRITE),      32'd0);
      chk("rst_paddr",     PADDR,            32'd0);
      chk("rst_pwdata",    PWDATA,           32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid),   32'd0);
      chk("rst_rsp_err",   32'(rsp_err),     32'd0);
      chk("rst_rsp_tmo",   32'(rsp_timeout), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata,        32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready),   32'd0);

      PRESET = 1'b0;
      @(posedge PCLK); #1;
      chk("ready_after_release", 32'(cmd_ready), 32'd1);
      @(negedge PCLK);

      // Zero-wait write: PSEL 2 cycles, PENABLE 1, rsp 3 cycles after accept
      xfer(1'b1, 32'h04, 32'hA5A5_0001, 1, 32'hFFFF_FFFF, 1'b0);
      chk_xfer("wr0", 2, 1, 3, 1'b0, 1'b0, 32'h0);

      // Read with 3 wait cycles, ready on the 4th ACCESS cycle
      xfer(1'b0, 32'h08, 32'h0, 4, 32'h1234_5678, 1'b0);
      chk_xfer("rd3w", 5, 4, 6, 1'b0, 1'b0, 32'h1234_5678);

      // Slave error on a read
      xfer(1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
      chk_xfer("rderr", 2, 1, 3, 1'b1, 1'b0, 32'hDEAD_BEEF);

      // Timeout: 16 ACCESS cycles without PREADY, rdata untouched
      xfer(1'b0, 32'h20, 32'h0, 0, 32'hCAFE_0000, 1'b0);
      chk_xfer("tmo", 17, 16, 18, 1'b1, 1'b1, 32'hDEAD_BEEF);

      // PREADY on the 16th ACCESS cycle completes normally
      xfer(1'b0, 32'h24, 32'h0, 16, 32'h0BAD_F00D, 1'b0);
      chk_xfer("rdy16", 17, 16, 18, 1'b0, 1'b0, 32'h0BAD_F00D);

      // Write with one wait and slave error: rdata keeps the last read value
      xfer(1'b1, 32'h2C, 32'h5555_AAAA, 2, 32'h1111_1111, 1'b1);
      chk_xfer("wrerr", 3, 2, 4, 1'b1, 1'b0, 32'h0BAD_F00D);

      // Reset during ACCESS drops the bus without a clock edge
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("mid_rst_in_access", 32'({PSEL, PENABLE}), 32'd3);
      #2 PRESET = 1'b1;
      #1;
      chk("mid_rst_psel",    32'(PSEL),      32'd0);
      chk("mid_rst_penable", 32'(PENABLE),   32'd0);
      chk("mid_rst_ready",   32'(cmd_ready), 32'd0);
      seen_rsp = 0;
      repeat (2) begin
         @(negedge PCLK);
         if (rsp_valid) seen_rsp++;
      end
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
      repeat (3) begin
         @(negedge PCLK);
         if (rsp_valid || PSEL) seen_rsp++;
      end
      chk("mid_rst_no_rsp", 32'(seen_rsp), 32'd0);

      // Back-to-back: cmd_valid held for three accepts
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
      PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h7777_0000;
      n_rsp = 0; n_acc = 0; bad_pen = 0; prev_psel = 1'b0; prev_pen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (n_acc == 3) cmd_valid = 1'b0;
         if (rsp_valid) begin
            if (n_rsp < 4) rsp_cyc[n_rsp] = k;
            n_rsp++;
         end
         if (PENABLE && !(PSEL && prev_psel && !prev_pen)) bad_pen++;
         prev_psel = PSEL; prev_pen = PENABLE;
         if (cmd_valid && cmd_ready) begin
            if (n_acc < 4) acc_cyc[n_acc] = k;
            n_acc++;
         end
         @(negedge PCLK);
      end
      PREADY = 1'b0;
      chk("b2b_accepts",    32'(n_acc),   32'd3);
      chk("b2b_rsp_pulses", 32'(n_rsp),   32'd3);
      chk("b2b_bad_pen",    32'(bad_pen), 32'd0);
      if (n_acc >= 3 && n_rsp >= 3) begin
         chk("b2b_first_rsp", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd3);
         chk("b2b_rsp_gap1",  32'(rsp_cyc[1] - rsp_cyc[0]), 32'd4);
         chk("b2b_rsp_gap2",  32'(rsp_cyc[2] - rsp_cyc[1]), 32'd4);
         chk("b2b_acc_gap1",  32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
         chk("b2b_acc_gap2",  32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
      end
      chk("b2b_rdata", rsp_rdata, 32'h7777_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
